// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t       receiver FSM state encoding
//   UART_DATA_WIDTH  default data bits per frame
//   UART_OVERSAMPLE  default baud_tick pulses per bit period
//   tick_cnt_width() width of the per-bit oversample counter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Counter must hold OVERSAMPLE-1.
  function automatic int unsigned tick_cnt_width(input int unsigned os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, resetting to all ones
// (idle-high lines read as idle while reset is held).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   d      asynchronous input
//   q      synchronised output
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity_receiver.sv
// Serial asynchronous receiver with optional parity check.
// Detects the start bit, samples each bit at mid-bit using baud_tick
// oversampling, deserialises LSB first, checks parity and stop bit, and
// hands each word out over a valid/ready handshake.
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to take every bit value as
// the 2-of-3 majority of the samples at mid-bit-2, mid-bit-1 and mid-bit.
// Otherwise a single mid-bit sample is used. Timing is identical.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   rxd         serial line (asynchronous, idle high)
//   baud_tick   one-cycle enable at OVERSAMPLE x baud rate
//   parity_en   frame carries a parity bit (latched at start confirmation)
//   odd         odd parity when 1, even when 0 (latched at start confirmation)
//   dout        received word
//   dout_valid  word available
//   dout_ready  consumer accepts the word
//   parity_err  parity mismatch for dout, qualified by dout_valid
//   frame_err   stop bit sampled low, qualified by dout_valid
//   overrun     sticky: a frame completed while a word was pending
//   busy        FSM not idle
module uart_rx_parity_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  baud_tick,
  input  logic                  parity_en,
  input  logic                  odd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned TW = tick_cnt_width(OVERSAMPLE);
  localparam int unsigned BW = (DATA_WIDTH <= 2) ? 1 : $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  rx_state_t state;
  rx_state_t state_next;

  logic                  rxd_s;
  logic                  bit_val;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_acc;
  logic                  perr_r;
  logic                  par_en_l;

  logic start_mid;
  logic bit_end;
  logic frame_done;
  logic accept;
  logic handshake;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rxd_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Samples from the two previous ticks; together with the current sample
  // they cover mid-bit-2, mid-bit-1 and mid-bit at every decision point.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '1;
    end else if (baud_tick) begin
      hist <= {hist[0], rxd_s};
    end
  end

  always_comb begin
    bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
  end
`else
  always_comb begin
    bit_val = rxd_s;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (baud_tick && !rxd_s) state_next = START;
      START:   if (start_mid) state_next = bit_val ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_BIT))
                 state_next = par_en_l ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    busy       = (state != IDLE);
    start_mid  = baud_tick && (state == START) && (tick_cnt == MID_TICK);
    bit_end    = baud_tick && (tick_cnt == LAST_TICK) &&
                 ((state == DATA) || (state == PARITY) || (state == STOP));
    frame_done = bit_end && (state == STOP);
    accept     = !dout_valid || dout_ready;
    handshake  = dout_valid && dout_ready;
  end

  // Bit timing, deserialiser and serial parity accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_acc <= 1'b0;
      perr_r     <= 1'b0;
      par_en_l   <= 1'b0;
    end else if (baud_tick) begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
        end
        START: begin
          if (start_mid) begin
            tick_cnt <= '0;
            if (!bit_val) begin
              bit_cnt    <= '0;
              shreg      <= '0;
              parity_acc <= odd;
              par_en_l   <= parity_en;
              perr_r     <= 1'b0;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt       <= '0;
            shreg[bit_cnt] <= bit_val;
            parity_acc     <= parity_acc ^ bit_val;
            bit_cnt        <= bit_cnt + BW'(1);
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            perr_r   <= bit_val ^ parity_acc;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) tick_cnt <= '0;
          else         tick_cnt <= tick_cnt + TW'(1);
        end
        default: begin
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Output word register and handshake. A completion in the same cycle as a
  // handshake is written last, so the new word replaces the consumed one and
  // dout_valid stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (handshake) begin
        dout_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (frame_done) begin
        if (accept) begin
          dout       <= shreg;
          parity_err <= par_en_l & perr_r;
          frame_err  <= ~bit_val;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_parity_receiver.md
Name: uart_rx_parity_receiver

Overview:
- Serial asynchronous receiver. Receive-side counterpart of the transmit path that serialises data and appends a serially computed parity bit.
- Detects the start bit, oversamples each bit at mid-bit, deserialises LSB-first, recomputes parity serially and checks the received parity bit and stop bit.
- Presents each word with error flags over a valid/ready handshake to the bus-side peripheral register logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >= 8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  serial line, asynchronous, idle high.
- baud_tick  in  1  one-cycle enable at OVERSAMPLE x baud rate.
- parity_en  in  1  1 = frame contains a parity bit.
- odd  in  1  1 = odd parity, 0 = even; sampled at start-bit confirmation.
- dout  out  DATA_WIDTH  received word.
- dout_valid  out  1  word available.
- dout_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch for the word in dout; qualified by dout_valid.
- frame_err  out  1  stop bit sampled low; qualified by dout_valid.
- overrun  out  1  sticky; a frame completed while dout_valid was high. Cleared by a handshake.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0; the FSM goes to IDLE; the synchroniser flops go to 1 (line idle). Asserting reset mid-frame aborts the frame and discards partial data.
- rxd passes through a 2-FF synchroniser before use. All FSM and counter activity advances only on cycles where baud_tick is high.
- FSM states:
  - IDLE: a synchronised rxd of 0 on a tick moves to START and clears tick_cnt.
  - START: when tick_cnt reaches OVERSAMPLE/2-1 (mid start bit), sample rxd.
    - If 1: false start, return to IDLE with no flags.
    - If 0: go to DATA; clear tick_cnt and bit_cnt; parity_acc <= odd.
  - DATA: every OVERSAMPLE ticks, sample one bit into shift register position bit_cnt (LSB first); parity_acc ^= bit. After DATA_WIDTH bits, go to PARITY if parity_en, otherwise go to STOP.
  - PARITY: sample after OVERSAMPLE ticks; perr = sample ^ parity_acc.
  - STOP: sample after OVERSAMPLE ticks. The stop sample drives the completion handling below, then the FSM returns to IDLE in the same cycle.
- Frame completion (on the stop sample):
  - If dout_valid is 0 or dout_ready is 1 that cycle: load dout, set parity_err (0 if !parity_en), set frame_err = ~sample, set dout_valid = 1 on the next clk edge.
  - If dout_valid is 1 and dout_ready is 0: new data is dropped, dout and flags are unchanged, overrun is set.
- Latency: dout_valid rises one clk after the baud_tick edge on which the mid-stop sample is taken.
- Handshake:
  - dout_valid & dout_ready consumes the word: dout_valid drops next cycle unless a completion coincides, in which case the new word loads and valid stays high. overrun clears.
  - dout and the flags hold stable while dout_valid is high.
- A frame_err with rxd still low does not block the next frame. IDLE waits for the next 0 sample, so a break condition produces repeated framed-error words of 0x00.
- Changing parity_en or odd mid-frame has no effect on the current frame; both are latched at start confirmation.

Optional Feature:
- UART_RX_MAJORITY_VOTE_EN.
  - Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of the samples at ticks OVERSAMPLE/2-2, -1 and 0 relative to mid-bit. Requires OVERSAMPLE >= 8.
  - Undefined: a single sample at mid-bit.
- Timing and latency are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - default DATA_WIDTH/OVERSAMPLE constants;
  - a function computing tick_cnt width from OVERSAMPLE.
- One natural sub-module: sync_2ff, the generic reset-to-1 two-flop synchroniser with asynchronous active-low reset. Parity accumulation stays inline.

Test Plan:
- 8N1, byte 0xA5, dout_ready held 1 -> dout=0xA5, dout_valid high exactly 1 cycle, parity_err=0, frame_err=0.
- 8 data bits, parity_en=1, odd=0, byte 0x07 with parity bit 1 -> parity_err=0; the same frame with parity bit 0 -> parity_err=1, dout=0x07.
- Odd parity, byte 0x00 with parity bit 1 -> parity_err=0. Stop bit forced 0 -> frame_err=1.
- 0-glitch on rxd of 3 ticks in IDLE -> false start, busy returns to 0, no dout_valid.
- dout_ready=0, send 0x11 then 0x22 -> dout=0x11 held, overrun=1. One handshake -> overrun=0, dout_valid=0.
- Assert reset mid DATA of 0x5A, release, send 0x3C -> only 0x3C delivered, all flags 0. Repeat with UART_RX_MAJORITY_VOTE_EN and a single-tick mid-bit glitch -> data unaffected.
